merge_tree: RTL and testbench

Pipelined, parametrised N-way compaction merger with valid/ready flow control. It takes NUM_IN fixed-size vectors, each carrying a variable number of valid elements. It concatenates the valid elements, in input order, into one densely packed output vector through a log2(NUM_IN)-level binary tree of registered pairwise merges. It sits in the compression datapath after the per-channel encoders and ahead of the output packer, accepting one input set per cycle at full throughput.

---
 rtl/merge_tree.sv | 147 ++++++++++++++
 tb/tb_merge_tree.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_tree.sv
`default_nettype none
// ============================================================================
// Module      : merge_tree
// Description : Pipelined NUM_IN-way compaction merger. A log2(NUM_IN)-level
//               binary tree of registered pairwise merges with valid/ready flow.
//               Optional macro MERGE_PAD_EN: unused slots carry PAD, not 0.
// Revision    : 1.0 - initial release
// ============================================================================
module merge_tree #(
  parameter int                WIDTH  = 16,
  parameter int                LEN    = 10,
  parameter int                NUM_IN = 4,
  parameter logic [WIDTH-1:0]  PAD    = '0,
  localparam int               LW     = $clog2(LEN + 1),
  localparam int               OW     = $clog2(NUM_IN * LEN + 1),
  localparam int               L      = $clog2(NUM_IN)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_IN*LEN*WIDTH-1:0]  in_data,
  input  logic [NUM_IN*LW-1:0]         in_len,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_IN*LEN*WIDTH-1:0]  out_data,
  output logic [OW-1:0]                out_len
);

  localparam int c_totw = NUM_IN * LEN * WIDTH;
`ifdef MERGE_PAD_EN
  localparam logic [WIDTH-1:0] c_fill = PAD;
`else
  localparam logic [WIDTH-1:0] c_fill = PAD & '0;
`endif

  logic [L-1:0]        r_v;
  logic [c_totw-1:0]   r_data     [L];
  logic [OW-1:0]       r_len      [L][NUM_IN];

  logic                w_src_v    [L];
  logic [c_totw-1:0]   w_src_data [L];
  logic [OW-1:0]       w_src_len  [L][NUM_IN];
  logic [c_totw-1:0]   w_nxt_data [L];
  logic [OW-1:0]       w_nxt_len  [L][NUM_IN];
  logic [L-1:0]        w_load;

  // Load chain runs from the output back to the input, so a stall ripples
  // combinationally to in_ready while empty stages still absorb data.
  always_comb begin : p_load
    logic w_adv;
    w_adv  = out_ready;
    w_load = '0;
    for (int k = L - 1; k >= 0; k--) begin
      w_load[k] = !r_v[k] || w_adv;
      w_adv     = w_load[k];
    end
  end

  assign in_ready = w_load[0];

  for (genvar k = 0; k < L; k++) begin : g_level
    localparam int S  = LEN << k;
    localparam int NN = NUM_IN >> (k + 1);

    if (k == 0) begin : g_src_in
      assign w_src_v[k]    = in_valid;
      assign w_src_data[k] = in_data;
      for (genvar m = 0; m < NUM_IN; m++) begin : g_clamp
        logic [LW-1:0] w_raw;
        assign w_raw            = in_len[(NUM_IN-1-m)*LW +: LW];
        assign w_src_len[k][m]  = (w_raw > LW'(LEN)) ? OW'(LEN) : OW'(w_raw);
      end
    end else begin : g_src_reg
      assign w_src_v[k]    = r_v[k-1];
      assign w_src_data[k] = r_data[k-1];
      assign w_src_len[k]  = r_len[k-1];
    end

    for (genvar j = 0; j < NN; j++) begin : g_node
      logic [S*WIDTH-1:0]   w_a;
      logic [S*WIDTH-1:0]   w_b;
      logic [OW-1:0]        w_la;
      logic [OW-1:0]        w_lb;
      logic [2*S*WIDTH-1:0] w_ext_b;
      logic [2*S*WIDTH-1:0] w_m;

      assign w_a  = w_src_data[k][c_totw-1-(2*j)*S*WIDTH -: S*WIDTH];
      assign w_b  = w_src_data[k][c_totw-1-(2*j+1)*S*WIDTH -: S*WIDTH];
      assign w_la = w_src_len[k][2*j];
      assign w_lb = w_src_len[k][2*j+1];
      // Right child slid down to start right after the left child's last element.
      assign w_ext_b = {w_b, {(S*WIDTH){1'b0}}} >> (int'(w_la) * WIDTH);

      always_comb begin
        w_m = '0;
        for (int i = 0; i < S; i++) begin
          if (OW'(i) < w_la)
            w_m[(2*S-1-i)*WIDTH +: WIDTH] = w_a[(S-1-i)*WIDTH +: WIDTH];
          else if (OW'(i) < w_la + w_lb)
            w_m[(2*S-1-i)*WIDTH +: WIDTH] = w_ext_b[(2*S-1-i)*WIDTH +: WIDTH];
          else
            w_m[(2*S-1-i)*WIDTH +: WIDTH] = c_fill;
        end
        for (int i = S; i < 2 * S; i++) begin
          if (OW'(i) < w_la + w_lb)
            w_m[(2*S-1-i)*WIDTH +: WIDTH] = w_ext_b[(2*S-1-i)*WIDTH +: WIDTH];
          else
            w_m[(2*S-1-i)*WIDTH +: WIDTH] = c_fill;
        end
      end

      assign w_nxt_data[k][c_totw-1-j*2*S*WIDTH -: 2*S*WIDTH] = w_m;
      assign w_nxt_len[k][j] = w_la + w_lb;
    end

    for (genvar j = NN; j < NUM_IN; j++) begin : g_idle
      assign w_nxt_len[k][j] = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_v <= '0;
      for (int k = 0; k < L; k++) begin
        r_data[k] <= '0;
        for (int m = 0; m < NUM_IN; m++) r_len[k][m] <= '0;
      end
    end else begin
      for (int k = 0; k < L; k++) begin
        if (w_load[k]) begin
          r_v[k] <= w_src_v[k];
          if (w_src_v[k]) begin
            r_data[k] <= w_nxt_data[k];
            for (int m = 0; m < NUM_IN; m++) r_len[k][m] <= w_nxt_len[k][m];
          end
        end
      end
    end
  end

  assign out_valid = r_v[L-1];
  assign out_data  = r_data[L-1];
  assign out_len   = r_len[L-1][0];

endmodule
`default_nettype wire

// File: tb/tb_merge_tree.sv
`default_nettype none
// ============================================================================
// Module      : tb_merge_tree
// Description : Self-checking bench for merge_tree against an element-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_merge_tree;

  localparam int WIDTH  = 16;
  localparam int LEN    = 10;
  localparam int NUM_IN = 4;
  localparam int LW     = $clog2(LEN + 1);
  localparam int OW     = $clog2(NUM_IN * LEN + 1);
  localparam int TOTW   = NUM_IN * LEN * WIDTH;
`ifdef MERGE_PAD_EN
  localparam logic [WIDTH-1:0] PAD_VAL = 16'hFFFF;
  localparam logic [WIDTH-1:0] FILL    = 16'hFFFF;
`else
  localparam logic [WIDTH-1:0] PAD_VAL = 16'h5A5A;
  localparam logic [WIDTH-1:0] FILL    = 16'h0000;
`endif

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [TOTW-1:0]    in_data = '0;
  logic [NUM_IN*LW-1:0] in_len = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [TOTW-1:0]    out_data;
  logic [OW-1:0]      out_len;

  int vectors = 0;
  int errors  = 0;

  logic [TOTW-1:0] exp_d[$];
  logic [TOTW-1:0] got_d[$];
  int              exp_l[$];
  int              got_l[$];

  merge_tree #(.WIDTH(WIDTH), .LEN(LEN), .NUM_IN(NUM_IN), .PAD(PAD_VAL)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_len(in_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_len(out_len)
  );

  always #5 clock = ~clock;

  // Gather the surviving elements of every input in order, then lay them out.
  function automatic void model(input logic [TOTW-1:0] d, input logic [NUM_IN*LW-1:0] l,
                                output logic [TOTW-1:0] od, output int ol);
    logic [WIDTH-1:0] elems[$];
    int n;
    for (int i = 0; i < NUM_IN; i++) begin
      n = int'(l[(NUM_IN-1-i)*LW +: LW]);
      if (n > LEN) n = LEN;
      for (int e = 0; e < n; e++) elems.push_back(d[TOTW-1-(i*LEN+e)*WIDTH -: WIDTH]);
    end
    ol = elems.size();
    od = '0;
    for (int s = 0; s < NUM_IN * LEN; s++)
      od[TOTW-1-s*WIDTH -: WIDTH] = (s < ol) ? elems[s] : FILL;
  endfunction

  task automatic rand_set(input int maxlen);
    for (int w = 0; w < TOTW / 32; w++) in_data[w*32 +: 32] = $urandom;
    for (int i = 0; i < NUM_IN; i++) in_len[i*LW +: LW] = LW'($urandom_range(0, maxlen));
  endtask

  // Inputs are driven at the falling edge; handshakes are recorded just before the rising edge.
  task automatic step();
    logic [TOTW-1:0] md;
    int ml;
    #1;
    if (reset) begin
      exp_d.delete(); exp_l.delete();
    end else begin
      if (out_valid && out_ready) begin
        got_d.push_back(out_data); got_l.push_back(int'(out_len));
      end
      if (in_valid && in_ready) begin
        model(in_data, in_len, md, ml);
        exp_d.push_back(md); exp_l.push_back(ml);
      end
    end
    @(negedge clock);
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    exp_d.delete(); exp_l.delete(); got_d.delete(); got_l.delete();
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    vectors++; if (out_len !== '0) begin errors++; $display("FAIL reset_out_len: got %0d want 0", out_len); end
    vectors++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    @(negedge clock);
  endtask

  task automatic test_directed();
    logic [TOTW-1:0] e;
    idle();
    for (int s = 0; s < LEN; s++) begin
      in_data[TOTW-1-(0*LEN+s)*WIDTH -: WIDTH] = 16'hA000 + 16'(s);
      in_data[TOTW-1-(1*LEN+s)*WIDTH -: WIDTH] = 16'hB000 + 16'(s);
      in_data[TOTW-1-(2*LEN+s)*WIDTH -: WIDTH] = 16'hC000 + 16'(s);
      in_data[TOTW-1-(3*LEN+s)*WIDTH -: WIDTH] = 16'hD000 + 16'(s);
    end
    in_len = {4'd3, 4'd0, 4'd10, 4'd1};
    e = {(NUM_IN*LEN){FILL}};
    for (int s = 0; s < 3; s++)  e[TOTW-1-s*WIDTH -: WIDTH] = 16'hA000 + 16'(s);
    for (int s = 0; s < 10; s++) e[TOTW-1-(3+s)*WIDTH -: WIDTH] = 16'hC000 + 16'(s);
    e[TOTW-1-13*WIDTH -: WIDTH] = 16'hD000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL directed_early_valid: got %0b want 0", out_valid); end
    step();
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL directed_latency: got %0b want 1", out_valid); end
    vectors++; if (out_len !== OW'(14)) begin errors++; $display("FAIL directed_len: got %0d want 14", out_len); end
    vectors++; if (out_data !== e) begin errors++; $display("FAIL directed_data: got %0h want %0h", out_data, e); end
  endtask

  task automatic test_back_to_back();
    idle();
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin rand_set(LEN + 3); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      if (c < 8) begin
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready c=%0d: got %0b want 1", c, in_ready); end
      end
      step();
      vectors++;
      if (out_valid !== ((c + 1 >= 2) && (c + 1 <= 9))) begin
        errors++; $display("FAIL b2b_out_valid cycle=%0d: got %0b want %0b", c + 1, out_valid, (c + 1 >= 2) && (c + 1 <= 9));
      end
    end
    vectors++; if (got_l.size() != 8 || exp_l.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_l.size(), exp_l.size()); end
    for (int i = 0; i < got_l.size() && i < exp_l.size(); i++) begin
      vectors++;
      if (got_d[i] !== exp_d[i] || got_l[i] != exp_l[i]) begin
        errors++; $display("FAIL b2b_set%0d: got len %0d data %0h want len %0d data %0h", i, got_l[i], got_d[i], exp_l[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [TOTW-1:0] hold_d;
    logic [OW-1:0]   hold_l;
    int sent;
    logic acc;
    idle();
    sent = 0;
    hold_d = '0; hold_l = '0;
    rand_set(LEN); in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c >= 7);
      #1;
      if (c < 2) begin
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_fill_ready c=%0d: got %0b want 1", c, in_ready); end
      end else if (c < 7) begin
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c=%0d: got %0b want 0", c, in_ready); end
        if (c == 2) begin hold_d = out_data; hold_l = out_len; end
        else begin
          vectors++;
          if (out_valid !== 1'b1 || out_data !== hold_d || out_len !== hold_l) begin
            errors++; $display("FAIL stall_hold c=%0d: got len %0d data %0h want len %0d data %0h", c, out_len, out_data, hold_l, hold_d);
          end
        end
      end
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        sent++;
        if (sent < 6) rand_set(LEN); else in_valid = 1'b0;
      end
    end
    vectors++; if (got_l.size() != 6 || exp_l.size() != 6) begin errors++; $display("FAIL stall_count: got %0d want %0d", got_l.size(), exp_l.size()); end
    for (int i = 0; i < got_l.size() && i < exp_l.size(); i++) begin
      vectors++;
      if (got_d[i] !== exp_d[i] || got_l[i] != exp_l[i]) begin
        errors++; $display("FAIL stall_set%0d: got len %0d data %0h want len %0d data %0h", i, got_l[i], got_d[i], exp_l[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_clamp();
    logic [TOTW-1:0] md;
    int ml;
    idle();
    rand_set(0);
    in_len = {4'd2, 4'd2, 4'd15, 4'd2};
    model(in_data, in_len, md, ml);
    in_valid = 1'b1; step(); in_valid = 1'b0; step();
    vectors++; if (out_len !== OW'(16)) begin errors++; $display("FAIL clamp_len: got %0d want 16", out_len); end
    vectors++; if (out_data !== md) begin errors++; $display("FAIL clamp_data: got %0h want %0h", out_data, md); end
  endtask

  task automatic test_boundary();
    logic [TOTW-1:0] full;
    idle();
    rand_set(0);
    in_len = '0;
    in_valid = 1'b1; step(); in_valid = 1'b0; step();
    vectors++; if (out_len !== '0) begin errors++; $display("FAIL empty_len: got %0d want 0", out_len); end
    vectors++; if (out_data !== {(NUM_IN*LEN){FILL}}) begin errors++; $display("FAIL empty_data: got %0h want %0h", out_data, {(NUM_IN*LEN){FILL}}); end
    rand_set(0);
    for (int i = 0; i < NUM_IN; i++) in_len[i*LW +: LW] = LW'(LEN);
    full = in_data;
    in_valid = 1'b1; step(); in_valid = 1'b0; step();
    vectors++; if (out_len !== OW'(NUM_IN * LEN)) begin errors++; $display("FAIL full_len: got %0d want %0d", out_len, NUM_IN * LEN); end
    vectors++; if (out_data !== full) begin errors++; $display("FAIL full_data: got %0h want %0h", out_data, full); end
  endtask

  task automatic test_pad();
    logic [TOTW-1:0] md;
    int ml;
    idle();
    rand_set(0);
    for (int i = 0; i < NUM_IN; i++) in_len[i*LW +: LW] = 4'd5;
    model(in_data, in_len, md, ml);
    in_valid = 1'b1; step(); in_valid = 1'b0; step();
    vectors++; if (out_len !== OW'(20)) begin errors++; $display("FAIL pad_len: got %0d want 20", out_len); end
    for (int s = 20; s < NUM_IN * LEN; s++) begin
      vectors++;
      if (out_data[TOTW-1-s*WIDTH -: WIDTH] !== FILL) begin
        errors++; $display("FAIL pad_slot%0d: got %0h want %0h", s, out_data[TOTW-1-s*WIDTH -: WIDTH], FILL);
      end
    end
    vectors++; if (out_data !== md) begin errors++; $display("FAIL pad_data: got %0h want %0h", out_data, md); end
  endtask

  task automatic test_reset_midflight();
    logic [TOTW-1:0] md;
    int ml;
    idle();
    out_ready = 1'b0;
    rand_set(LEN); in_valid = 1'b1; step();
    rand_set(LEN); step();
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_full_valid: got %0b want 1", out_valid); end
    out_ready = 1'b1;
    rand_set(LEN);
    reset = 1'b1; step(); reset = 1'b0;
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    vectors++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %0h want 0", out_data); end
    vectors++; if (out_len !== '0) begin errors++; $display("FAIL rst_out_len: got %0d want 0", out_len); end
    rand_set(LEN + 3);
    model(in_data, in_len, md, ml);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_post_early: got %0b want 0", out_valid); end
    step();
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_post_valid: got %0b want 1", out_valid); end
    vectors++;
    if (out_data !== md || out_len !== OW'(ml)) begin
      errors++; $display("FAIL rst_post_set: got len %0d data %0h want len %0d data %0h", out_len, out_data, ml, md);
    end
    step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_dup: got %0b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic acc;
    idle();
    in_valid = 1'b0;
    acc = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_set(LEN + 3);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      acc = in_valid && in_ready;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    vectors++; if (got_l.size() != exp_l.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", got_l.size(), exp_l.size()); end
    for (int i = 0; i < got_l.size() && i < exp_l.size(); i++) begin
      vectors++;
      if (got_d[i] !== exp_d[i] || got_l[i] != exp_l[i]) begin
        errors++; $display("FAIL rand_set%0d: got len %0d data %0h want len %0d data %0h", i, got_l[i], got_d[i], exp_l[i], exp_d[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_clamp();
    test_boundary();
    test_pad();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
